// File: rtl/alu_mc_if.sv
// Handshake and data bundle between the operand-fetch stage, alu_mc and the writeback stage.
// master drives commands and consumes results; slave is the ALU side.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, in1, in2, sel, out_ready,
    input  in_ready, out_valid, ans, carry, zero
  );

  modport slave (
    input  in_valid, in1, in2, sel, out_ready,
    output in_ready, out_valid, ans, carry, zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define ALU_MC_FAST_MUL_EN to replace the multiplier with a single-cycle combinational one.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave io
);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ABS = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

`ifdef ALU_MC_FAST_MUL_EN
  typedef enum logic [0:0] {IDLE, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
`endif

  state_e state_q, state_d;

  logic             in_ready, out_valid, accept;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res;
  logic             res_c;

`ifdef ALU_MC_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
`else
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               start_mul;
`endif

  assign accept = io.in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
`ifdef ALU_MC_FAST_MUL_EN
          state_d = DONE;
`else
          state_d = (op_e'(io.sel) == OP_MUL) ? MUL : DONE;
`endif
        end
      end
`ifndef ALU_MC_FAST_MUL_EN
      MUL:     if (&cnt_q) state_d = DONE;
`endif
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle result for every opcode except the iterative multiply
  always_comb begin
    sum   = {1'b0, io.in1} + {1'b0, io.in2};
    diff  = {1'b0, io.in1} - {1'b0, io.in2};
`ifdef ALU_MC_FAST_MUL_EN
    prod  = {{WIDTH{1'b0}}, io.in1} * {{WIDTH{1'b0}}, io.in2};
`endif
    res   = '0;
    res_c = 1'b0;
    case (op_e'(io.sel))
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      // A borrow out of the single subtractor means in2 > in1: negate the difference
      OP_ABS: res = diff[WIDTH] ? (~diff[WIDTH-1:0] + 1'b1) : diff[WIDTH-1:0];
      OP_OR:  res = io.in1 | io.in2;
      OP_AND: res = io.in1 & io.in2;
      OP_XOR: res = io.in1 ^ io.in2;
`ifdef ALU_MC_FAST_MUL_EN
      OP_MUL: begin
        res   = prod[WIDTH-1:0];
        res_c = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      OP_SHL: res = io.in1 << io.in2[SW-1:0];
      OP_EQ:  res = (io.in1 == io.in2) ? '1 : '0;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ans_d   = ans_q;
    carry_d = carry_q;
    zero_d  = zero_q;
`ifdef ALU_MC_FAST_MUL_EN
    if (accept) begin
`else
    start_mul = accept && (op_e'(io.sel) == OP_MUL);
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    if (start_mul) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, io.in1};
      mplier_d = io.in2;
      cnt_d    = '0;
    end
    if (state_q == MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (&cnt_q) begin
        ans_d   = acc_step[WIDTH-1:0];
        carry_d = |acc_step[2*WIDTH-1:WIDTH];
        zero_d  = (acc_step[WIDTH-1:0] == '0);
      end
    end
    if (accept && !start_mul) begin
`endif
      ans_d   = res;
      carry_d = res_c;
      zero_d  = (res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifndef ALU_MC_FAST_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      ans_q    <= ans_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifndef ALU_MC_FAST_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.ans       = ans_q;
  assign io.carry     = carry_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized commands against a behavioural model.
module tb_alu_mc;
  localparam int unsigned W = 32;
`ifdef ALU_MC_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 0;
`else
  localparam int unsigned MUL_LAT = W;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, ans} straight from the opcode definitions
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] s);
    logic [2*W-1:0] p;
    logic [W:0]     r;
    case (s)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, (a > b) ? a - b : b - a};
      3'd2: r = {1'b0, a | b};
      3'd3: r = {1'b0, a & b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = {p[2*W-1:W] != 0, p[W-1:0]};
      end
      3'd6: r = {1'b0, a << (b % W)};
      default: r = {1'b0, (a == b) ? {W{1'b1}} : {W{1'b0}}};
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE, check latency/result, hold out_ready low for 'stall' cycles, consume.
  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                         input int unsigned stall, input string tag);
    logic [W:0]  exp;
    int unsigned cyc;
    int unsigned lat;
    exp = model(a, b, s);
    lat = (s == 3'd5) ? MUL_LAT : 0;
    check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.sel = s;
    tick();
    bus.in_valid = 1'b0;
    bus.in1 = $urandom;
    bus.in2 = $urandom;
    bus.sel = 3'($urandom);
    cyc = 0;
    while (!bus.out_valid && cyc < 3 * W) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".ans"},   64'(bus.ans),   64'(exp[W-1:0]));
    check({tag, ".carry"}, 64'(bus.carry), 64'(exp[W]));
    check({tag, ".zero"},  64'(bus.zero),  64'(exp[W-1:0] == 0));
    for (int i = 0; i < int'(stall); i++) begin
      bus.in_valid = 1'b1;
      bus.in1 = $urandom;
      bus.in2 = $urandom;
      bus.sel = 3'($urandom);
      tick();
      check({tag, ".stall_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".stall_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, ".stall_flags"}, {31'd0, bus.carry, bus.zero, bus.ans},
            {31'd0, exp[W], exp[W-1:0] == 0, exp[W-1:0]});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".post_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, ".post_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   s;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.sel       = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst.in_ready",  64'(bus.in_ready),  64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.ans",       64'(bus.ans),       64'd0);
    check("rst.carry",     64'(bus.carry),     64'd0);
    check("rst.zero",      64'(bus.zero),      64'd0);
    rst_n = 1'b1;
    tick();

    run_cmd(32'hFFFF_FFFF, 32'd1, 3'd0, 5, "add_wrap");
    run_cmd(32'd3, 32'd10, 3'd1, 0, "abs_lt");
    run_cmd(32'd10, 32'd3, 3'd1, 0, "abs_gt");
    run_cmd(32'd1, 32'd35, 3'd6, 0, "shl_mod");
    run_cmd(32'd5, 32'd5, 3'd7, 0, "eq_same");
    run_cmd(32'd5, 32'd6, 3'd7, 1, "eq_diff");
    run_cmd(32'h0001_0000, 32'h0001_0000, 3'd5, 2, "mul_ovf");
    run_cmd(32'd123, 32'd456, 3'd5, 0, "mul_small");
    run_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 0, "mul_max");
    run_cmd(32'hF0F0_1234, 32'h0F0F_4321, 3'd2, 0, "or");
    run_cmd(32'hF0F0_1234, 32'h0F0F_4321, 3'd3, 0, "and");
    run_cmd(32'hF0F0_1234, 32'hF0F0_1234, 3'd4, 0, "xor_zero");

    // Reset in the middle of a multiply abandons it
    bus.in_valid = 1'b1;
    bus.in1 = 32'd123;
    bus.in2 = 32'd456;
    bus.sel = 3'd5;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst.ans",       64'(bus.ans),       64'd0);
    check("midrst.in_ready",  64'(bus.in_ready),  64'd1);
    run_cmd(32'd2, 32'd2, 3'd0, 0, "add_after_rst");

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      s = 3'($urandom);
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_FFFF;
      run_cmd(a, b, s, $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
